// File: rtl/divideby3_fsm.sv
// Divide-by-DIV Moore FSM: q is high for one clock in every DIV.
// Asynchronous active-high reset parks the machine in S0 (q = 1).
module divideby3_fsm #(
  parameter int DIV = 3
) (
  input  logic clk,
  input  logic reset,
  output logic q
);

  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [W-1:0] S0   = '0;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] state_q;
  logic [W-1:0] state_d;

  // Next state: count up, wrap at the last state; unused codes fall back to S0.
  always_comb begin
    state_d = S0;
    if (state_q < LAST)
      state_d = state_q + 1'b1;
  end

  // State register with asynchronous reset to S0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= S0;
    else
      state_q <= state_d;
  end

  // Moore output decoded from the state register only.
  assign q = (state_q == S0);

endmodule

// File: tb/tb_divideby3_fsm.sv
// Self-checking bench for divideby3_fsm.
// Reference model: a phase counter modulo DIV, q expected when phase is 0.
module tb_divideby3_fsm;

  localparam int DIV = 3;

  logic clk;
  logic reset;
  logic q;

  int checks = 0;
  int errors = 0;

  int phase   = 0;
  int cyc     = 0;
  int rise_at = -1;
  logic last_q = 1'b1;

  divideby3_fsm #(.DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge; advance the model and compare.
  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    if (reset)
      phase = 0;
    else
      phase = (phase + 1) % DIV;
    cyc++;
    chk(tag, q, (phase == 0));
  endtask

  // Tick and also measure pulse spacing and width from observed q.
  task automatic tick_period();
    tick("free_run");
    if (q && !last_q) begin
      if (rise_at >= 0)
        chk_int("period", cyc - rise_at, DIV);
      rise_at = cyc;
    end
    if (!q && last_q && rise_at >= 0)
      chk_int("high_width", cyc - rise_at, 1);
    last_q = q;
  endtask

  // Change reset in the middle of the low clock phase.
  task automatic set_reset(input logic v);
    @(negedge clk);
    #2;
    reset = v;
    if (v) phase = 0;
  endtask

  task automatic run_to_phase(input int p);
    for (int i = 0; i < DIV + 1; i++) begin
      if (phase == p) break;
      tick("seek");
    end
    chk_int("seek_phase", phase, p);
  endtask

  initial begin
    reset = 1'b1;

    // Reset hold across several edges.
    for (int i = 0; i < 4; i++)
      tick("reset_hold");

    // Release and check the 0,0,1 pattern three times over.
    set_reset(1'b0);
    #1;
    chk("post_release", q, 1'b1);
    for (int i = 0; i < 9; i++)
      tick("release_seq");

    // Free run with period / width measurement.
    last_q  = q;
    rise_at = -1;
    for (int i = 0; i < 30; i++)
      tick_period();

    // Asynchronous reset while in S1, then in S2.
    for (int s = 1; s <= 2; s++) begin
      run_to_phase(s);
      set_reset(1'b1);
      #1;
      chk(s == 1 ? "async_s1" : "async_s2", q, 1'b1);
      for (int i = 0; i < 2; i++)
        tick("async_hold");
      set_reset(1'b0);
      for (int i = 0; i < 3; i++)
        tick("restart_seq");
    end

    // Randomized run lengths and reset pulses.
    for (int r = 0; r < 25; r++) begin
      int n;
      int hold;
      n    = $urandom_range(1, 8);
      hold = $urandom_range(0, 3);
      for (int i = 0; i < n; i++)
        tick("rand_run");
      set_reset(1'b1);
      #1;
      chk("rand_async", q, 1'b1);
      for (int i = 0; i < hold; i++)
        tick("rand_hold");
      #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++)
        tick("rand_seq");
    end

    // Illegal encoding recovery: code 3 must return to S0.
    run_to_phase(2);
    @(negedge clk);
    #2;
    force dut.state_q = 2'd3;
    #1;
    chk("illegal_q", q, 1'b0);
    release dut.state_q;
    for (int i = 0; i < 4; i++)
      tick("illegal_recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
